// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module   : cla_pipe_adder
// Brief    : Pipelined carry-lookahead adder/subtractor, one BLOCK_WID slice
//            per stage, with valid/ready flow control.
// Revision : 1.0 - initial release
// ============================================================================
module cla_pipe_adder #(
    parameter int DATA_WID  = 64,
    parameter int BLOCK_WID = 16
) (
    input  logic                Clock,
    input  logic                ResetN,
    input  logic                InValid,
    output logic                InReady,
    input  logic [DATA_WID-1:0] InputA,
    input  logic [DATA_WID-1:0] InputB,
    input  logic                CarryInput,
    input  logic                Subtract,
    output logic                OutValid,
    input  logic                OutReady,
    output logic [DATA_WID-1:0] Sum,
    output logic                CarryOutput,
    output logic                Overflow,
    output logic                Zero
);

    localparam int STAGES = DATA_WID / BLOCK_WID;

    // Stage s register bank; the last bank is the output register.
    logic [DATA_WID-1:0] q_a [STAGES];
    logic [DATA_WID-1:0] q_b [STAGES];
    logic [DATA_WID-1:0] q_s [STAGES];
    logic                q_c [STAGES];
    logic                q_v [STAGES];
    logic                ovf_q;
    logic                zero_q;

    logic [DATA_WID-1:0] src_a [STAGES];
    logic [DATA_WID-1:0] src_b [STAGES];
    logic [DATA_WID-1:0] src_s [STAGES];
    logic                src_c [STAGES];
    logic                src_v [STAGES];
    logic [DATA_WID-1:0] nxt_s [STAGES];
    logic                nxt_c [STAGES];
    logic                msb_cin;
    logic                ovf_nxt;
    logic                zero_nxt;
    logic                advance;

    assign advance = ~OutValid | OutReady;
    assign InReady = advance;

    always_comb begin
        logic c;
        logic g;
        logic p;
        int   idx;
        c   = 1'b0;
        g   = 1'b0;
        p   = 1'b0;
        idx = 0;
        msb_cin  = 1'b0;
        src_a[0] = InputA;
        src_b[0] = Subtract ? ~InputB : InputB;
        src_s[0] = '0;
        src_c[0] = CarryInput ^ Subtract;
        src_v[0] = InValid;
        for (int s = 1; s < STAGES; s++) begin
            src_a[s] = q_a[s-1];
            src_b[s] = q_b[s-1];
            src_s[s] = q_s[s-1];
            src_c[s] = q_c[s-1];
            src_v[s] = q_v[s-1];
        end
        for (int s = 0; s < STAGES; s++) begin
            c        = src_c[s];
            nxt_s[s] = src_s[s];
            for (int i = 0; i < BLOCK_WID; i++) begin
                idx = s * BLOCK_WID + i;
                g   = src_a[s][idx] & src_b[s][idx];
                p   = src_a[s][idx] | src_b[s][idx];
                nxt_s[s][idx] = src_a[s][idx] ^ src_b[s][idx] ^ c;
                if (idx == DATA_WID - 1) begin
                    msb_cin = c;
                end
                c = g | (p & c);
            end
            nxt_c[s] = c;
        end
        ovf_nxt  = msb_cin ^ nxt_c[STAGES-1];
        zero_nxt = (nxt_s[STAGES-1] == '0);
    end

    // One global enable: a stalled output freezes every bank, keeping slices aligned.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            for (int s = 0; s < STAGES; s++) begin
                q_a[s] <= '0;
                q_b[s] <= '0;
                q_s[s] <= '0;
                q_c[s] <= 1'b0;
                q_v[s] <= 1'b0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            for (int s = 0; s < STAGES; s++) begin
                q_a[s] <= src_a[s];
                q_b[s] <= src_b[s];
                q_s[s] <= nxt_s[s];
                q_c[s] <= nxt_c[s];
                q_v[s] <= src_v[s];
            end
            ovf_q  <= ovf_nxt;
            zero_q <= zero_nxt;
        end
    end

    assign OutValid    = q_v[STAGES-1];
    assign Sum         = q_s[STAGES-1];
    assign CarryOutput = q_c[STAGES-1];
    assign Overflow    = ovf_q;
    assign Zero        = zero_q;

endmodule
`default_nettype wire
